// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic              spec;
  logic [XLEN-1:0]   spec_val;

  logic            a_sgn, b_sgn, na, nb;
  logic [XLEN-1:0] a_in, b_in;
  logic            b_zero, ovf, fast;
  logic [XLEN-1:0] fast_val;

  always_comb begin
    a_sgn  = (op == 3'b001) || (op == 3'b010) ||
             (op == 3'b100) || (op == 3'b110);
    b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    na     = a_sgn & a[XLEN-1];
    nb     = b_sgn & b[XLEN-1];
    a_in   = na ? -a : a;
    b_in   = nb ? -b : b;
    b_zero = (b == '0);
    ovf    = op[2] && !op[0] && (b == '1) &&
             (a == {1'b1, {(XLEN-1){1'b0}}});
    fast   = op[2] && (b_zero || ovf);
    if (b_zero) fast_val = op[1] ? a : '1;
    else        fast_val = op[1] ? '0 : a;
  end

  // One step of shift-add multiply and of restoring division
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     div_sh;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nx;

  always_comb begin
    addend  = acc[0] ? a_mag : '0;
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    mul_nx  = {mul_sum, acc[XLEN-1:1]};
    div_sh  = {rem, acc[XLEN-1]};
    q_bit   = (div_sh >= {1'b0, b_mag});
    rem_nx  = q_bit ? (div_sh[XLEN-1:0] - b_mag) : div_sh[XLEN-1:0];
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix, r_fix, fix_val;

  always_comb begin
    prod    = (neg_a ^ neg_b) ? -acc : acc;
    q_fix   = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_fix   = neg_a ? -rem : rem;
    fix_val = '0;
    if (spec) begin
      fix_val = spec_val;
    end else begin
      unique case (1'b1)
        !op_q[2] && (op_q[1:0] == 2'b00): fix_val = prod[XLEN-1:0];
        !op_q[2] && (op_q[1:0] != 2'b00): fix_val = prod[2*XLEN-1:XLEN];
        op_q[2] && !op_q[1]:               fix_val = q_fix;
        op_q[2] && op_q[1]:                fix_val = r_fix;
        default:                           fix_val = '0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = fast ? FIX : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      spec     <= 1'b0;
      spec_val <= '0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= (state == FIX);
      if (state == IDLE && start) begin
        op_q     <= op;
        neg_a    <= na;
        neg_b    <= nb;
        a_mag    <= a_in;
        b_mag    <= b_in;
        spec     <= fast;
        spec_val <= fast_val;
        cnt      <= CW'(XLEN);
        rem      <= '0;
        acc      <= {{XLEN{1'b0}}, op[2] ? a_in : b_in};
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (op_q[2]) begin
          acc <= {{XLEN{1'b0}}, acc[XLEN-2:0], q_bit};
          rem <= rem_nx;
        end else begin
          acc <= mul_nx;
        end
      end
      if (state == FIX) result <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, scoreboard on done,
// latency/busy counts, abort, ignored start and back-to-back issue.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001,
    MULHSU = 3'b010, MULHU = 3'b011, DIV = 3'b100,
    DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: result %h want none", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(e);
    #1 start = 1'b0;
  endtask

  // Called #1 after an edge; counts edges until done and busy samples
  task automatic wait_done(input string nm, input int lat,
                           input int bexp, input int inj);
    int cyc = 0;
    int bc;
    bit got = 0;
    bc = busy ? 1 : 0;
    while (!got && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; op = DIVU; a = 32'd5; b = 32'd0;
      end else if (inj != 0 && cyc == inj + 1) begin
        start = 1'b0;
      end
      if (done) got = 1;
      else if (busy) bc++;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles want %0d",
               nm, cyc, lat);
    end else begin
      chk({nm, "_latency"}, cyc, lat);
      chk({nm, "_busy_cycles"}, bc, bexp);
      chk({nm, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    end
  endtask

  vec_t vec[16];

  initial begin
    vec[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0};
    vec[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0};
    vec[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0};
    vec[3]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0};
    vec[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0};
    vec[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0};
    vec[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       0};
    vec[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        0};
    vec[8]  = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vec[9]  = '{REMU,   32'd5,        32'd0,        32'd5,        1};
    vec[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vec[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vec[12] = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        0};
    vec[13] = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        0};
    vec[14] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vec[15] = '{MUL,    32'h12345678, 32'h10,       32'h23456780, 0};

    reset = 1'b1; start = 1'b0; op = MUL; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(vec[i].op, vec[i].a, vec[i].b, vec[i].exp);
      wait_done($sformatf("vec%0d", i), vec[i].fast ? 1 : 33,
                vec[i].fast ? 1 : 33, 0);
    end

    // start pulsed mid-flight must be ignored
    issue(MUL, 32'h1234, 32'h10, 32'h12340);
    wait_done("ignored_start", 33, 33, 6);

    // abort by reset 10 cycles after accept
    issue(MUL, 32'd5, 32'd6, 32'd30);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    begin
      int dn = 0;
      repeat (40) begin
        @(posedge clk);
        #1 if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
    end
    issue(MUL, 32'd3, 32'd4, 32'd12);
    wait_done("after_abort", 33, 33, 0);

    // back-to-back: start held high, new op on each done cycle
    @(negedge clk);
    start = 1'b1; op = MUL; a = 32'd7; b = 32'hFFFFFFFD;
    @(posedge clk);
    exp_q.push_back(32'hFFFFFFEB);
    #1;
    wait_done("b2b0", 33, 33, 0);
    op = DIVU; a = 32'd100; b = 32'd7;
    exp_q.push_back(32'd14);
    wait_done("b2b1", 34, 33, 0);
    op = DIVU; a = 32'd5; b = 32'd0;
    exp_q.push_back(32'hFFFFFFFF);
    wait_done("b2b2", 2, 1, 0);
    op = REMU; a = 32'd5; b = 32'd0;
    exp_q.push_back(32'd5);
    wait_done("b2b3", 2, 1, 0);
    start = 1'b0;

    repeat (40) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operation set, parametrised in datapath width. Sits beside the single-cycle ALU in the execute stage: the core issues an M-extension operation with a start pulse and stalls until `done`. One result bit is produced per cycle. Divide-by-zero and signed overflow take a short fast path.

## Interface
- `XLEN`, 32, operand/result width; must be ≥ 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (multiplicand/dividend).
- `b`  in  XLEN  rs2 operand (multiplier/divisor).
- `busy`  out  1  operation in flight; new `start` ignored.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  XLEN  registered result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `start`=1 at an edge latches `op`, `a`, `b` and sign flags. Magnitudes are latched as |a| and |b| for signed operands, raw values otherwise. The edge then goes to CALC with bit counter = XLEN, or directly to FIX if a special case is detected.
- Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MUL, MULHU, DIVU and REMU are unsigned in the core; MUL's low half is sign-agnostic.
- CALC, multiply: unsigned shift-add into a 2·XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division of the magnitudes, one quotient bit per cycle with an XLEN+1-bit partial remainder.
- Counter decrements each cycle. The edge where the counter reaches 1 moves to FIX.
- FIX, result selection:
  - Product is negated if the operand signs differ (signed ops only). MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - The FIX edge registers `result`, sets `done`=1 for one cycle and returns to IDLE.
- Special cases (decided at accept, no CALC):
  - b=0: DIV/DIVU → all ones; REM/REMU → `a`.
  - DIV with a=most negative and b=all ones → `a`; REM with the same operands → 0.
- `start` while `busy`=1 is ignored, with no queueing. Operand inputs need not be held after the accept edge.
- `start`=1 in the cycle `done`=1 is accepted (back-to-back issue).

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state=IDLE, counter=0.
- Accept at edge N. `busy`=1 from the cycle after N up to and including the cycle containing the FIX edge.
- Normal latency: CALC spans edges N+1..N+XLEN and FIX is edge N+XLEN+1. `done`=1 and `busy`=0 in the cycle after edge N+XLEN+1. For XLEN=32 that is 33 edges.
- Fast path: FIX at edge N+1, so `done`=1 in the cycle after edge N+1.
- `done` is never high for two consecutive cycles unless a back-to-back fast-path operation completes.
- `reset`=1 at any edge, including mid-CALC, aborts the operation. It forces all reset values at that edge, and no `done` is produced for the aborted operation.
- `result` changes only on a FIX edge or on reset.

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` in the cycle after edge N+33; `busy` high for exactly 33 cycles.
- MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0. Each completes with `done` in the cycle after edge N+1.
- Mid-operation: `reset` pulsed 10 cycles after accept → `busy`=0, `result`=0, no `done` pulse. Then MUL 3×4 → 12.
- Back-to-back: `start` held high continuously with a new op each `done` → every op is accepted on its `done` cycle. A `start` pulse while `busy`=1 leaves `result` and latency of the in-flight op unchanged.
